iter_divider: RTL and testbench

Parametrised iterative RISC-V divider (DIV/DIVU/REM/REMU) for the execute-stage MDU.
- Retires BITS_PER_CYCLE quotient bits per cycle using a restoring shift-subtract datapath.
- Uses valid/ready handshakes on both request and response, and carries a tag alongside each operation.
- Resolves divide-by-zero and signed overflow on a one-cycle fast path, and supports flush with a defined response drop.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/div_step.sv | 22 ++
 rtl/iter_divider.sv | 165 ++++++++++++++++
 tb/tb_iter_divider.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU types: divider opcodes, divider FSM states and a two's-complement helper.
package mdu_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Callers zero-extend into MAX_WIDTH and truncate the result back;
    // the low bits of a wide negate equal the narrow negate.
    function automatic logic [MAX_WIDTH-1:0] abs_twos(input logic [MAX_WIDTH-1:0] value,
                                                      input logic negate);
        return negate ? (~value + MAX_WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract, keep if non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit with valid/ready handshakes, tag passthrough,
// one-cycle fast path for divide-by-zero / signed overflow, and flush.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high unless flushing
//   CALC  | BITS_PER_CYCLE restoring steps per cycle on |a| / |b|
//   DONE  | result held on rsp_data/rsp_tag until rsp_ready
module iter_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_opcode,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 busy
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
        $error("iter_divider: WIDTH must be a multiple of BITS_PER_CYCLE");
    end
    if (WIDTH > MAX_WIDTH || WIDTH < 8) begin : g_bad_width
        $error("iter_divider: WIDTH out of supported range");
    end

    div_state_e           state;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     divisor_q;
    logic [CNT_W-1:0]     cnt;
    logic                 q_neg_q;
    logic                 r_neg_q;
    logic                 is_rem_q;

    div_op_e              op;
    logic                 op_unsigned;
    logic                 op_rem;
    logic                 a_neg;
    logic                 b_neg;
    logic                 div_zero;
    logic                 sgn_ovf;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    logic [WIDTH:0]            rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [WIDTH-1:0]          quo_next;
    logic [WIDTH:0]            rem_next;
    logic [WIDTH-1:0]          final_data;

    assign op          = div_op_e'(req_opcode);
    assign op_unsigned = (op == DIVU) || (op == REMU);
    assign op_rem      = (op == REM) || (op == REMU);
    assign a_neg       = ~op_unsigned & req_a[WIDTH-1];
    assign b_neg       = ~op_unsigned & req_b[WIDTH-1];
    assign div_zero    = (req_b == '0);
    assign sgn_ovf     = ~op_unsigned && (req_a == {1'b1, {(WIDTH-1){1'b0}}}) && (req_b == '1);
    assign abs_a       = WIDTH'(abs_twos(MAX_WIDTH'(req_a), a_neg));
    assign abs_b       = WIDTH'(abs_twos(MAX_WIDTH'(req_b), b_neg));

    assign req_ready = (state == IDLE) & ~flush;
    assign busy      = (state != IDLE);

    // The dividend lives in quo_q and is shifted out MSB-first as quotient bits shift in.
    assign rem_chain[0] = rem_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in       (rem_chain[i]),
            .dividend_bit (quo_q[WIDTH-1-i]),
            .divisor      (divisor_q),
            .rem_out      (rem_chain[i+1]),
            .q_bit        (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    assign rem_next   = rem_chain[BITS_PER_CYCLE];
    assign quo_next   = {quo_q[WIDTH-1-BITS_PER_CYCLE:0], q_bits};
    assign final_data = is_rem_q
        ? WIDTH'(abs_twos(MAX_WIDTH'(rem_next[WIDTH-1:0]), r_neg_q))
        : WIDTH'(abs_twos(MAX_WIDTH'(quo_next), q_neg_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            is_rem_q  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_tag <= req_tag;
                        cnt     <= '0;
                        if (div_zero) begin
                            rsp_data  <= op_rem ? req_a : '1;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else if (sgn_ovf) begin
                            rsp_data  <= op_rem ? '0 : req_a;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= abs_a;
                            divisor_q <= abs_b;
                            q_neg_q   <= a_neg ^ b_neg;
                            r_neg_q   <= a_neg;
                            is_rem_q  <= op_rem;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (cnt == CNT_W'(STEPS-1)) begin
                        cnt       <= '0;
                        rsp_data  <= final_data;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: vector table, corner sequences and random ops
// against an arithmetic reference, with BPC=1/2/4 instances sharing one stimulus stream.
module tb_iter_divider;

    localparam int W = 32;
    localparam int T = 5;

    logic          clk = 1'b0;
    logic          rst, flush, req_valid, rsp_ready;
    logic [1:0]    req_opcode;
    logic [W-1:0]  req_a, req_b;
    logic [T-1:0]  req_tag;

    logic          req_ready1, rsp_valid1, busy1;
    logic [W-1:0]  rsp_data1;
    logic [T-1:0]  rsp_tag1;
    logic          req_ready2, rsp_valid2, busy2;
    logic [W-1:0]  rsp_data2;
    logic [T-1:0]  rsp_tag2;
    logic          req_ready4, rsp_valid4, busy4;
    logic [W-1:0]  rsp_data4;
    logic [T-1:0]  rsp_tag4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1), .TAG_WIDTH(T)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready1),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
        .rsp_tag(rsp_tag1), .busy(busy1));

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(2), .TAG_WIDTH(T)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready2),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
        .rsp_tag(rsp_tag2), .busy(busy2));

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(4), .TAG_WIDTH(T)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready4),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
        .rsp_tag(rsp_tag4), .busy(busy4));

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] tag;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RISC-V division semantics from plain arithmetic; 64-bit signed math covers MIN/-1.
    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint sa, sb;
        logic [W-1:0] q, r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int bpc);
        bit fast;
        fast = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return fast ? 1 : W / bpc + 1;
    endfunction

    // Presents a request and returns #1 after the edge that accepts it.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [T-1:0] tag);
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_tag    = tag;
        req_valid  = 1'b1;
        #1;
        check("req_ready_before_accept", req_ready1, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag, input bit consume,
                         output logic [W-1:0] d, output logic [T-1:0] t,
                         output logic [W-1:0] d2, output logic [W-1:0] d4,
                         output int lat, output int lat2, output int lat4);
        start_op(op, a, b, tag);
        lat = 1; lat2 = 0; lat4 = 0;
        for (int k = 0; k < 100; k++) begin
            if (rsp_valid2 && lat2 == 0) lat2 = lat;
            if (rsp_valid4 && lat4 == 0) lat4 = lat;
            if (rsp_valid1) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_valid_within_budget", rsp_valid1, 1'b1);
        d  = rsp_data1;
        t  = rsp_tag1;
        d2 = rsp_data2;
        d4 = rsp_data4;
        if (consume) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic run_checked(input string name, input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [T-1:0] tag,
                               input logic [W-1:0] exp);
        logic [W-1:0] d, d2, d4;
        logic [T-1:0] t;
        int lat, lat2, lat4;
        do_op(op, a, b, tag, 1'b1, d, t, d2, d4, lat, lat2, lat4);
        check({name, "_data"}, d, exp);
        check({name, "_tag"}, t, tag);
        check({name, "_lat_bpc1"}, lat, ref_lat(op, a, b, 1));
        check({name, "_data_bpc2"}, d2, exp);
        check({name, "_lat_bpc2"}, lat2, ref_lat(op, a, b, 2));
        check({name, "_data_bpc4"}, d4, exp);
        check({name, "_lat_bpc4"}, lat4, ref_lat(op, a, b, 4));
        check({name, "_idle_after"}, busy1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d, d2, d4, hold_d;
        logic [T-1:0] t, hold_t;
        int lat, lat2, lat4;
        bit stable, seen;
        logic [1:0] rop;
        logic [W-1:0] ra, rb;

        vecs[0] = '{2'b00, 32'd20,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFFA};
        vecs[1] = '{2'b10, 32'd20,         32'hFFFF_FFFD, 5'd2,  32'd2};
        vecs[2] = '{2'b00, 32'hFFFF_FFEC,  32'd3,         5'd3,  32'hFFFF_FFFA};
        vecs[3] = '{2'b10, 32'hFFFF_FFEC,  32'd3,         5'd4,  32'hFFFF_FFFE};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF,  32'd1,         5'd5,  32'hFFFF_FFFF};
        vecs[5] = '{2'b00, 32'd5,          32'd0,         5'd6,  32'hFFFF_FFFF};
        vecs[6] = '{2'b11, 32'd7,          32'd0,         5'd7,  32'd7};
        vecs[7] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000};
        vecs[8] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opcode = '0; req_a = '0; req_b = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid1, 1'b0);
        check("reset_rsp_data", rsp_data1, '0);
        check("reset_rsp_tag", rsp_tag1, '0);
        check("reset_busy", busy1, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_req_ready", req_ready1, 1'b1);

        foreach (vecs[i])
            run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                        vecs[i].tag, vecs[i].exp);

        // Backpressure: result and tag must hold while the consumer stalls.
        do_op(2'b00, 32'd20, 32'hFFFF_FFFD, 5'd17, 1'b0, d, t, d2, d4, lat, lat2, lat4);
        hold_d = d; hold_t = t;
        check("bp_data", d, 32'hFFFF_FFFA);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid1 !== 1'b1 || rsp_data1 !== hold_d || rsp_tag1 !== hold_t ||
                req_ready1 !== 1'b0)
                stable = 1'b0;
            @(posedge clk);
            #1;
        end
        check("bp_stable_5_cycles", stable, 1'b1);
        check("bp_tag", rsp_tag1, 5'd17);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_release_busy", busy1, 1'b0);
        check("bp_release_rsp_valid", rsp_valid1, 1'b0);
        run_checked("bp_back_to_back", 2'b11, 32'd100, 32'd7, 5'd18, 32'd2);

        // Flush in the tenth CALC cycle drops the response entirely.
        start_op(2'b01, 32'hDEAD_BEEF, 32'd13, 5'd19);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
        end
        check("flush_pre_busy", busy1, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy1, 1'b0);
        check("flush_rsp_valid", rsp_valid1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid1 || rsp_valid2 || rsp_valid4) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush_no_response", seen, 1'b0);
        run_checked("after_flush", 2'b01, 32'd100, 32'd7, 5'd20, 32'd14);

        // A request presented together with flush in IDLE must be ignored.
        req_opcode = 2'b01; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd21;
        req_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_idle_req_ready", req_ready1, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_not_accepted", busy1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid1 || busy1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush_idle_no_response", seen, 1'b0);

        // Reset mid-CALC returns everything to reset values.
        start_op(2'b00, 32'd12345, 32'd67, 5'd22);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_rsp_valid", rsp_valid1, 1'b0);
        check("midrst_rsp_data", rsp_data1, '0);
        check("midrst_rsp_tag", rsp_tag1, '0);
        check("midrst_busy", busy1, 1'b0);
        run_checked("after_rst", 2'b11, 32'd100, 32'd7, 5'd23, 32'd2);

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = ~32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            run_checked($sformatf("rand%0d", n), rop, ra, rb, 5'(n), ref_div(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
